min_max_peak: RTL
=================

# min_max_peak

Registered, clocked successor of the combinational min/max LED bar. Captures a bar configuration (`com`, `min`, `max`, `value`) on a load strobe and generates the blink phase internally, replacing the external `osc_i`. Adds a peak-hold marker with timed hold and per-cycle decay. Drives the 2**VALSIZE LED bar of the display top level.

## Interface
Parameters:
- `VALSIZE`, default 4: width of values; the LED bar has 2**VALSIZE LEDs.
- `BLINK_DIV`, default 8: blink half-period in clock cycles, ≥1.
- `HOLD_CYCLES`, default 16: peak hold duration in cycles, ≥1.

Ports:
- `clk_i`, in, 1: single clock; all logic on its rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `load_i`, in, 1: when 1, sample `com_i`, `min_i`, `max_i` and `val_i` this edge.
- `com_i`, in, 2: mode. 00 normal, 01 linear, 10 all off, 11 all on.
- `min_i`, in, VALSIZE: bar lower bound.
- `max_i`, in, VALSIZE: bar upper bound.
- `val_i`, in, VALSIZE: current value.
- `peak_en_i`, in, 1: enables the peak marker overlay (live, not captured).
- `leds_o`, out, 2**VALSIZE: registered LED bar.
- `peak_o`, out, VALSIZE: registered current peak value.
- `err_o`, out, 1: registered; last load was rejected.

## Operation
- **Config registers** (`com`, `min`, `max`, `val`):
  - On `load_i`=1 with `min_i` ≤ `max_i`: all four are updated and `err_o` is cleared.
  - On `load_i`=1 with `min_i` > `max_i`: the load is rejected, registers keep their old values and `err_o` is set to 1 until the next accepted load.
- **Blink generator:**
  - Counter runs 0..BLINK_DIV-1 and wraps.
  - `blink` toggles on each wrap.
  - The counter free-runs and is not affected by loads.
- **Peak FSM** (states TRACK, HOLD, DECAY). It acts only on accepted loads and timer events; `peak_en_i` gates display only.
  - Any state, accepted load with `val_i` ≥ `peak`: `peak` := `val_i`, hold timer := HOLD_CYCLES-1, go to HOLD.
  - TRACK, accepted load with `val_i` < `peak`: `peak` unchanged, timer reloaded, go to HOLD.
  - HOLD, no qualifying load: timer decrements. When the timer is 0, go to DECAY. A lower load does not reload the timer.
  - DECAY: `peak` decrements by 1 per cycle while `peak` > `val`. When `peak` = `val`, go to TRACK. A lower load retargets the decay to the new `val`.
- **LED function**, evaluated on the registered config, then registered into `leds_o`:
  - 00, `val` within [`min`,`max`]: LEDs `min`..`val` = 1, LEDs `val`+1..`max` = `blink`, others 0.
  - 00, `val` outside [`min`,`max`]: all LEDs 0.
  - 01: LEDs 0..`val` = 1, others 0.
  - 10: all LEDs 0. 11: all LEDs 1. The peak overlay is ignored in both.
  - Peak overlay, modes 00/01 with `peak_en_i`=1: LED[`peak`] is forced to 1. In mode 00 this applies only when `peak` is within [`min`,`max`].
- **Width rules:**
  - Index arithmetic uses VALSIZE+1 bits, so `val`+1 never wraps when `val` = 2**VALSIZE-1.
  - `peak` never underflows, since decay stops at `val`.

## Timing
- **Reset values:**
  - Registers and counters: config `com`=10, `min`=`max`=`val`=0; blink counter 0; `blink`=1; `peak`=0; hold timer 0; state TRACK.
  - Outputs: `leds_o`=0, `peak_o`=0, `err_o`=0.
- **Reset priority:** `rst_i` overrides `load_i` and all FSM activity in the same cycle. Reset mid-hold or mid-decay returns to TRACK with `peak`=0 on the next edge.
- **Load latency:** `load_i` sampled at edge N → config and `peak` updated at N. `leds_o` and `peak_o` reflect them after edge N+1, and `err_o` is visible after edge N+1.
- **Blink latency:** a blink toggle at edge N is visible on `leds_o` after edge N+1.
- **Blink period:** 2·BLINK_DIV cycles.
- **Hold and decay:** with no further loads, decay starts HOLD_CYCLES cycles after the load that entered HOLD. It then steps `peak` by 1 per cycle.
- **Back-to-back loads:** every cycle is legal; each accepted load is processed independently.
- **Simultaneous events:** a load on the same edge as a timer expiry or decay step takes priority.

## Test plan
Bench settings: VALSIZE=4, BLINK_DIV=4, HOLD_CYCLES=3.
- **Reset:** assert `rst_i` for 2 cycles → `leds_o`=0, `peak_o`=0, `err_o`=0; `leds_o` stays 0 afterwards with no load.
- **Normal mode with blink:** load com=00, min=3, max=12, val=8, `peak_en_i`=0 → after 2 edges LEDs 3..8 = 1, LEDs 9..12 toggle every 4 cycles, all others 0.
- **Rejected load:** load min=9, max=2 → `err_o`=1 one edge later and `leds_o` unchanged. A following valid load clears `err_o`.
- **Peak hold and decay:** load com=01, val=10 with `peak_en_i`=1, then load val=4 → `peak_o`=10 holds for 3 cycles, then steps 9,8,…,4, one per cycle. LED[`peak_o`] tracks the peak and LEDs 0..4 stay lit.
- **Boundaries:**
  - com=00, min=0, max=15, val=15 → all 16 LEDs = 1.
  - com=00, val=2 with min=5, max=9 → all LEDs 0.
- **Reset mid-decay:** assert `rst_i` during DECAY → next edge `peak_o`=0 and `leds_o`=0; the same-cycle `load_i` is ignored.

Source files
------------

// File: rtl/min_max_peak.sv
// rtl/min_max_peak.sv - registered min/max LED bar with internal blink and peak-hold marker
module min_max_peak #(
  parameter int VALSIZE     = 4,
  parameter int BLINK_DIV   = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [1:0]            com_i,
  input  logic [VALSIZE-1:0]    min_i,
  input  logic [VALSIZE-1:0]    max_i,
  input  logic [VALSIZE-1:0]    val_i,
  input  logic                  peak_en_i,
  output logic [2**VALSIZE-1:0] leds_o,
  output logic [VALSIZE-1:0]    peak_o,
  output logic                  err_o
);

  localparam int NLEDS = 2 ** VALSIZE;
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {TRACK, HOLD, DECAY} state_t;

  logic [1:0]         com_r;
  logic [VALSIZE-1:0] min_r, max_r, val_r, peak_r;
  logic [CW-1:0]      blink_cnt;
  logic               blink;
  logic [TW-1:0]      hold_timer;
  state_t             state;
  logic               err_r;

  logic               accept, peak_qualify;
  logic               val_in_range, peak_in_range;
  logic [VALSIZE:0]   ix, val_p1;
  logic [NLEDS-1:0]   leds_next;

  assign accept        = load_i && (min_i <= max_i);
  assign peak_qualify  = accept && (val_i >= peak_r);
  assign val_in_range  = (min_r <= val_r) && (val_r <= max_r);
  assign peak_in_range = (min_r <= peak_r) && (peak_r <= max_r);
  // One extra bit so val+1 past the top LED does not wrap back to LED 0.
  assign val_p1        = {1'b0, val_r} + 1'b1;

  always_comb begin
    leds_next = '0;
    ix        = '0;
    for (int i = 0; i < NLEDS; i++) begin
      ix = (VALSIZE + 1)'(i);
      case (com_r)
        2'b00: begin
          if (val_in_range) begin
            if (ix >= {1'b0, min_r} && ix <= {1'b0, val_r})
              leds_next[i] = 1'b1;
            else if (ix >= val_p1 && ix <= {1'b0, max_r})
              leds_next[i] = blink;
          end
        end
        2'b01:   leds_next[i] = (ix <= {1'b0, val_r});
        2'b11:   leds_next[i] = 1'b1;
        default: leds_next[i] = 1'b0;
      endcase
    end
    if (peak_en_i && (com_r == 2'b01 || (com_r == 2'b00 && peak_in_range)))
      leds_next[peak_r] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      com_r      <= 2'b10;
      min_r      <= '0;
      max_r      <= '0;
      val_r      <= '0;
      peak_r     <= '0;
      blink_cnt  <= '0;
      blink      <= 1'b1;
      hold_timer <= '0;
      state      <= TRACK;
      err_r      <= 1'b0;
      leds_o     <= '0;
      peak_o     <= '0;
      err_o      <= 1'b0;
    end else begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (accept) begin
        com_r <= com_i;
        min_r <= min_i;
        max_r <= max_i;
        val_r <= val_i;
        err_r <= 1'b0;
      end else if (load_i) begin
        err_r <= 1'b1;
      end

      // A load outranks the timer expiry or decay step on the same edge.
      if (peak_qualify) begin
        peak_r     <= val_i;
        hold_timer <= HOLD_LOAD;
        state      <= HOLD;
      end else begin
        case (state)
          TRACK: begin
            if (accept) begin
              hold_timer <= HOLD_LOAD;
              state      <= HOLD;
            end
          end
          HOLD: begin
            if (hold_timer == '0) begin
              state <= DECAY;
              if (peak_r > val_r) peak_r <= peak_r - 1'b1;
            end else begin
              hold_timer <= hold_timer - 1'b1;
            end
          end
          DECAY: begin
            if (!accept) begin
              if (peak_r > val_r) peak_r <= peak_r - 1'b1;
              else                state  <= TRACK;
            end
          end
          default: state <= TRACK;
        endcase
      end

      leds_o <= leds_next;
      peak_o <= peak_r;
      err_o  <= err_r;
    end
  end

endmodule
